// File: rtl/decoder_strobe_sequencer.sv
// Sequences select/enable for a 1-to-2 active-low decoder: select is set up one cycle ahead, enable is held low HOLD_CYCLES, then a GAP_CYCLES quiet gap.
// Latency: accept to first strobe cycle is 2 edges; request spacing is 2+HOLD_CYCLES+GAP_CYCLES cycles. Backpressure: req_ready is high only in IDLE.
module decoder_strobe_sequencer #(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 1,
    parameter int CNT_W       = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_valid,
    input  logic req_sel,
    output logic req_ready,
    output logic dec_enable,
    output logic dec_in,
    output logic busy,
    output logic done
);

    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam bit HAS_GAP = (GAP_CYCLES > 0);
    localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(HAS_GAP ? GAP_CYCLES - 1 : 0);

    generate
        if (HOLD_CYCLES < 1 || HOLD_CYCLES > CNT_MAX) begin : g_bad_hold
            $error("HOLD_CYCLES out of range for CNT_W");
        end
        if (GAP_CYCLES < 0 || GAP_CYCLES > CNT_MAX) begin : g_bad_gap
            $error("GAP_CYCLES out of range for CNT_W");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_GAP
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_dec_enable;
    logic             r_dec_in;
    logic             r_done;
    logic             w_cnt_zero;

    assign w_cnt_zero = (r_cnt == '0);

    // dec_in only moves on the IDLE->SETUP transition, so it is stable whenever enable is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_dec_enable <= 1'b1;
            r_dec_in     <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_dec_in <= req_sel;
                        r_state  <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    r_state      <= S_STROBE;
                    r_cnt        <= HOLD_LD;
                    r_dec_enable <= 1'b0;
                end
                S_STROBE: begin
                    if (w_cnt_zero) begin
                        r_dec_enable <= 1'b1;
                        r_done       <= 1'b1;
                        if (HAS_GAP) begin
                            r_state <= S_GAP;
                            r_cnt   <= GAP_LD;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_GAP: begin
                    if (w_cnt_zero) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_dec_enable <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready  = (r_state == S_IDLE) && rst_n;
    assign busy       = (r_state != S_IDLE);
    assign dec_enable = r_dec_enable;
    assign dec_in     = r_dec_in;
    assign done       = r_done;

endmodule

// File: tb/tb_decoder_strobe_sequencer.sv
// Scoreboard bench for decoder_strobe_sequencer: default build (HOLD=4, GAP=1) plus a HOLD=1, GAP=0 build.
module tb_decoder_strobe_sequencer;

    localparam int H = 4;
    localparam int G = 1;

    logic clk = 1'b0;
    logic rst_n;
    logic req_valid, req_sel, req_ready, dec_enable, dec_in, busy, done;
    logic b_req_valid, b_req_sel, b_req_ready, b_dec_enable, b_dec_in, b_busy, b_done;

    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;
    int done_cnt = 0;

    typedef struct {
        logic sel;
        int   edge_n;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    bit   have_cur = 0;
    int   low_cnt = 0;
    logic prev_en = 1'b1;
    logic prev_in = 1'b0;

    decoder_strobe_sequencer #(.HOLD_CYCLES(H), .GAP_CYCLES(G), .CNT_W(8)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_sel    (req_sel),
        .req_ready  (req_ready),
        .dec_enable (dec_enable),
        .dec_in     (dec_in),
        .busy       (busy),
        .done       (done)
    );

    decoder_strobe_sequencer #(.HOLD_CYCLES(1), .GAP_CYCLES(0), .CNT_W(8)) u_dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (b_req_valid),
        .req_sel    (b_req_sel),
        .req_ready  (b_req_ready),
        .dec_enable (b_dec_enable),
        .dec_in     (b_dec_in),
        .busy       (b_busy),
        .done       (b_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Accepts are seen at the negedge before the edge that takes them.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            have_cur = 0;
            low_cnt  = 0;
            prev_en  = 1'b1;
        end else begin
            if (req_valid && req_ready) q.push_back('{sel: req_sel, edge_n: cyc + 1});
            if (!dec_enable) begin
                if (prev_en) begin
                    chk("strobe_has_req", int'(q.size() != 0), 1);
                    if (q.size() != 0) begin
                        cur = q.pop_front();
                        have_cur = 1;
                        chk("strobe_sel", int'(dec_in), int'(cur.sel));
                        chk("strobe_latency", cyc, cur.edge_n + 1);
                    end
                    low_cnt = 1;
                end else begin
                    chk("sel_stable", int'(dec_in), int'(prev_in));
                    low_cnt++;
                end
            end
            if (done) begin
                done_cnt++;
                chk("done_has_strobe", int'(have_cur), 1);
                if (have_cur) begin
                    chk("done_time", cyc, cur.edge_n + H + 1);
                    chk("hold_len", low_cnt, H);
                end
                have_cur = 0;
            end
            prev_en = dec_enable;
            prev_in = dec_in;
        end
    end

    task automatic wait_acc_a(output int e);
        int i = 0;
        @(negedge clk);
        while (!(req_ready && req_valid) && i < 40) begin
            @(negedge clk);
            i++;
        end
        chk("acc_a_wait", int'(req_ready && req_valid), 1);
        e = cyc + 1;
    endtask

    task automatic wait_acc_b(output int e);
        int i = 0;
        @(negedge clk);
        while (!(b_req_ready && b_req_valid) && i < 40) begin
            @(negedge clk);
            i++;
        end
        chk("acc_b_wait", int'(b_req_ready && b_req_valid), 1);
        e = cyc + 1;
    endtask

    task automatic wait_done_a();
        int i = 0;
        while (!done && i < 40) begin
            @(negedge clk);
            i++;
        end
        chk("done_wait", int'(done), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int e0, e1, e2, d0;
        rst_n = 1'b0;
        req_valid = 1'b1;
        req_sel = 1'b1;
        b_req_valid = 1'b0;
        b_req_sel = 1'b0;

        // reset state with a request pending
        repeat (3) @(negedge clk);
        chk("rst_ready", int'(req_ready), 0);
        chk("rst_enable", int'(dec_enable), 1);
        chk("rst_dec_in", int'(dec_in), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_b_ready", int'(b_req_ready), 0);
        @(posedge clk); #2;
        req_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_ready", int'(req_ready), 1);

        // single request, sel=1
        @(posedge clk); #2;
        req_valid = 1'b1;
        req_sel = 1'b1;
        wait_acc_a(e0);
        @(posedge clk); #2;
        req_valid = 1'b0;
        @(negedge clk);
        chk("setup_dec_in", int'(dec_in), 1);
        chk("setup_enable", int'(dec_enable), 1);
        wait_done_a();
        chk("gap_ready", int'(req_ready), 0);
        chk("gap_busy", int'(busy), 1);
        chk("gap_enable", int'(dec_enable), 1);
        @(negedge clk);
        chk("after_gap_ready", int'(req_ready), 1);
        chk("after_gap_edge", cyc, e0 + H + G + 1);

        // back-to-back with valid held: sel 0 then 1
        @(posedge clk); #2;
        req_valid = 1'b1;
        req_sel = 1'b0;
        wait_acc_a(e1);
        @(posedge clk); #2;
        req_sel = 1'b1;
        wait_acc_a(e2);
        chk("b2b_spacing", e2 - e1, 2 + H + G);
        @(posedge clk); #2;
        req_valid = 1'b0;

        // req_sel wiggles while busy must not reach dec_in
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #2;
            req_sel = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        chk("dec_in_hold", int'(dec_in), 1);
        chk("idle_after_b2b", int'(busy), 0);
        @(posedge clk); #2;
        req_valid = 1'b1;
        req_sel = 1'b0;
        wait_acc_a(e0);
        @(posedge clk); #2;
        req_valid = 1'b0;
        @(negedge clk);
        wait_done_a();

        // reset during the second strobe cycle
        @(posedge clk); #2;
        req_valid = 1'b1;
        req_sel = 1'b1;
        wait_acc_a(e0);
        @(posedge clk); #2;
        req_valid = 1'b0;
        for (int i = 0; i < 10 && dec_enable; i++) @(negedge clk);
        chk("mid_strobe_low", int'(dec_enable), 0);
        d0 = done_cnt;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("async_enable", int'(dec_enable), 1);
        chk("async_busy", int'(busy), 0);
        chk("async_ready", int'(req_ready), 0);
        chk("async_done", int'(done), 0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        chk("resume_ready", int'(req_ready), 1);
        repeat (12) @(negedge clk);
        chk("no_done_after_rst", done_cnt, d0);

        // HOLD=1, GAP=0 build
        @(posedge clk); #2;
        b_req_valid = 1'b1;
        b_req_sel = 1'b1;
        wait_acc_b(e1);
        @(negedge clk);
        chk("b_setup_enable", int'(b_dec_enable), 1);
        chk("b_setup_dec_in", int'(b_dec_in), 1);
        @(negedge clk);
        chk("b_strobe_enable", int'(b_dec_enable), 0);
        @(negedge clk);
        chk("b_done", int'(b_done), 1);
        chk("b_enable_back", int'(b_dec_enable), 1);
        chk("b_idle_ready", int'(b_req_ready), 1);
        e2 = cyc + 1;
        chk("b_spacing", e2 - e1, 3);
        @(posedge clk); #2;
        b_req_valid = 1'b0;
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/decoder_strobe_sequencer.md
Name: decoder_strobe_sequencer

Overview:
- Upstream driver for the 1-to-2 active-low enable/output decoder.
- Accepts select requests over a valid/ready handshake and drives the decoder's enable (active low) and select input with glitch-free timing.
- Select is set up one cycle before enable asserts, enable is held low for a fixed strobe width, and a minimum deassert gap follows.
- Produces clean, non-overlapping active-low strobes on decoder out0/out1.

Parameters:
- HOLD_CYCLES, 4: cycles dec_enable is held low per strobe; legal range 1..2^CNT_W-1 (elaboration error otherwise).
- GAP_CYCLES, 1: minimum cycles dec_enable stays high after a strobe before the next request is accepted; legal range 0..2^CNT_W-1.
- CNT_W, 8: width of the internal hold/gap down-counter.

Ports:
- clk  input  1  single system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_sel  input  1  target decoder output: 0 selects out0, 1 selects out1.
- req_ready  output  1  block can accept a request this cycle.
- dec_enable  output  1  to decoder enable; active low (0 = strobe active).
- dec_in  output  1  to decoder select input.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse when a strobe completes.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, dec_enable=1, dec_in=0, done=0, busy=0, counter=0.
  - req_ready is forced 0 while rst_n is low.
- Outputs:
  - dec_enable, dec_in and done are registered.
  - req_ready = (state==IDLE) and rst_n.
  - busy = (state!=IDLE).
- IDLE: req_ready=1. When req_valid & req_ready are sampled at edge k, latch req_sel into dec_in and go to SETUP.
- SETUP (exactly 1 cycle, after edge k):
  - dec_in holds the new select; dec_enable=1.
  - At edge k+1 go to STROBE and load counter with HOLD_CYCLES-1.
- STROBE:
  - dec_enable=0 for exactly HOLD_CYCLES cycles, after edges k+1 through k+HOLD_CYCLES.
  - Counter decrements each cycle.
  - At the edge where counter==0:
    - dec_enable returns to 1 and done pulses high for the following cycle.
    - If GAP_CYCLES>0, go to GAP and load counter with GAP_CYCLES-1; else go to IDLE.
- GAP: dec_enable=1 for GAP_CYCLES cycles, then IDLE.
- Latency and throughput:
  - Accept-to-first-strobe-cycle latency is 2 edges.
  - Minimum request-to-request spacing is 2+HOLD_CYCLES+GAP_CYCLES cycles (1 IDLE + 1 SETUP + HOLD + GAP).
- dec_in changes only in the cycle after an accept, never while dec_enable=0.
  - dec_in holds its last value through GAP and IDLE.
  - As a result, decoder outputs never glitch to the non-selected line.
- req_sel and req_valid are ignored while not in IDLE. A request held valid through busy is accepted on the first IDLE cycle.
- Reset asserted mid-strobe: dec_enable goes to 1 immediately (asynchronously), the request is dropped and no done is issued. After release, the block resumes from IDLE.
- At most one of the two decoder outputs is ever low. Both are high in every non-STROBE state.

Test Plan:
- Reset: hold rst_n=0 with req_valid=1 -> req_ready=0, dec_enable=1, dec_in=0, done=0, busy=0. Release -> req_ready=1 on the first cycle.
- Single request, HOLD=4, GAP=1: req_sel=1 accepted at edge 10 -> dec_in=1 after edge 10; dec_enable=0 after edges 11..14; dec_enable=1 and done=1 after edge 15; GAP cycle follows; req_ready=1 again after edge 16.
- Back-to-back, req_valid held high with req_sel 0 then 1: second accept occurs exactly 7 cycles after the first. dec_in flips only while dec_enable=1, and no cycle has both decoder outputs low.
- GAP_CYCLES=0, HOLD_CYCLES=1: one-cycle strobe with done pulse -> return to IDLE; next accept 3 cycles after the previous.
- Reset mid-strobe (rst_n low during the 2nd STROBE cycle) -> dec_enable=1 within the same cycle, no done pulse, state IDLE after release.
- req_sel toggled during STROBE/GAP -> dec_in unchanged until the next accepted request.
